// File: rtl/aes_key_sched_128.sv
// Sequential AES-128 key schedule: expands one round key per cycle from a loaded
// cipher key and keeps all 11 round keys in a buffer with a synchronous read port.

module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign o_s = sbox(i_a);
endmodule

module aes_key_sched_128 #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    input  logic [31:0]  rcon,
    output logic [127:0] rk,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic         done,
    output logic         busy,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data
);
    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t       r_state;
    logic [31:0]  r_w0, r_w1, r_w2, r_w3;
    logic [3:0]   r_round;
    logic         r_valid;
    logic         r_busy;
    logic [127:0] r_buf [0:NR];
    logic [127:0] r_rd_data;

    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;

    assign w_rot = {r_w3[23:0], r_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_a (w_rot[8*g +: 8]),
            .o_s (w_sub[8*g +: 8])
        );
    end

    assign w_t  = w_sub ^ rcon;
    assign w_n0 = r_w0 ^ w_t;
    assign w_n1 = r_w1 ^ w_n0;
    assign w_n2 = r_w2 ^ w_n1;
    assign w_n3 = r_w3 ^ w_n2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_w0      <= '0;
            r_w1      <= '0;
            r_w2      <= '0;
            r_w3      <= '0;
            r_round   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_rd_data <= '0;
            // NOTE: the buffer must read back as zero after reset, so it is built
            // from resettable flops rather than an inferred RAM macro.
            for (int i = 0; i <= NR; i++) r_buf[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make a same-edge read of the entry
            // being written return its old contents (read-before-write).
            r_rd_data <= (rd_addr <= LAST) ? r_buf[rd_addr] : '0;
            if (kld) begin
                {r_w0, r_w1, r_w2, r_w3} <= key;
                r_round  <= '0;
                r_valid  <= 1'b1;
                r_busy   <= 1'b1;
                r_state  <= EXPAND;
                r_buf[0] <= key;
            end else if (r_state == EXPAND) begin
                if (r_round < LAST) begin
                    {r_w0, r_w1, r_w2, r_w3}  <= {w_n0, w_n1, w_n2, w_n3};
                    r_round                   <= r_round + 4'd1;
                    r_buf[r_round + 4'd1]     <= {w_n0, w_n1, w_n2, w_n3};
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign rk       = {r_w0, r_w1, r_w2, r_w3};
    assign rk_valid = r_valid;
    assign rk_round = r_round;
    assign busy     = r_busy;
    assign done     = r_valid && (r_round == LAST);
    assign rd_data  = r_rd_data;
endmodule

// File: tb/tb_aes_key_sched_128.sv
// Directed bench for aes_key_sched_128 with a behavioural aes_rcon in the loop;
// expected round keys are the FIPS-197 vectors for the test and all-zero keys.

module tb_aes_key_sched_128;
    logic         clk = 1'b0;
    logic         rst;
    logic         kld;
    logic [127:0] key;
    logic [31:0]  rcon;
    logic [127:0] rk;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic         done;
    logic         busy;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_sched_128 dut (
        .clk      (clk),
        .rst      (rst),
        .kld      (kld),
        .key      (key),
        .rcon     (rcon),
        .rk       (rk),
        .rk_valid (rk_valid),
        .rk_round (rk_round),
        .done     (done),
        .busy     (busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    // Round-constant source: restarts at Rcon[1] after each kld edge.
    logic [3:0] rc_idx;
    always @(posedge clk) begin
        if (rst)                          rc_idx <= 4'd0;
        else if (kld)                     rc_idx <= 4'd1;
        else if (rc_idx != 0 && rc_idx < 10) rc_idx <= rc_idx + 4'd1;
    end

    always_comb begin
        rcon = 32'h0;
        case (rc_idx)
            4'd1:  rcon = 32'h01000000;
            4'd2:  rcon = 32'h02000000;
            4'd3:  rcon = 32'h04000000;
            4'd4:  rcon = 32'h08000000;
            4'd5:  rcon = 32'h10000000;
            4'd6:  rcon = 32'h20000000;
            4'd7:  rcon = 32'h40000000;
            4'd8:  rcon = 32'h80000000;
            4'd9:  rcon = 32'h1b000000;
            4'd10: rcon = 32'h36000000;
            default: rcon = 32'h0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k);
        kld = 1'b1;
        key = k;
        tick();
        kld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; kld = 1'b0; key = '0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if (rk !== 128'h0 || rd_data !== 128'h0) begin
            bad++; $display("FAIL reset_data: rk=%h rd_data=%h expected 0", rk, rd_data);
        end
        total++;
        if ({rk_valid, rk_round, done, busy} !== 7'b0) begin
            bad++; $display("FAIL reset_flags: valid=%b round=%0d done=%b busy=%b expected all 0",
                            rk_valid, rk_round, done, busy);
        end
    endtask

    task automatic test_fips();
        load(FIPS_RK[0]);
        for (int r = 0; r <= 10; r++) begin
            total++;
            if (rk !== FIPS_RK[r] || rk_round !== 4'(r)) begin
                bad++; $display("FAIL fips_round%0d: rk=%h round=%0d expected %h round=%0d",
                                r, rk, rk_round, FIPS_RK[r], r);
            end
            total++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || done !== (r == 10)) begin
                bad++; $display("FAIL fips_flags%0d: valid=%b busy=%b done=%b expected 1 1 %b",
                                r, rk_valid, busy, done, (r == 10));
            end
            if (r < 10) tick();
        end
        tick();
        total++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 ||
            rk !== FIPS_RK[10] || rk_round !== 4'd10) begin
            bad++; $display("FAIL fips_complete: busy=%b valid=%b done=%b round=%0d rk=%h expected 0 0 0 10 %h",
                            busy, rk_valid, done, rk_round, rk, FIPS_RK[10]);
        end
    endtask

    task automatic test_readback();
        for (int a = 0; a <= 10; a++) begin
            rd_addr = 4'(a);
            tick();
            total++;
            if (rd_data !== FIPS_RK[a]) begin
                bad++; $display("FAIL readback%0d: got %h expected %h", a, rd_data, FIPS_RK[a]);
            end
        end
    endtask

    task automatic test_reload_mid();
        int done_cnt;
        load(FIPS_RK[0]);
        repeat (5) tick();
        total++;
        if (rk_round !== 4'd5 || rk !== FIPS_RK[5]) begin
            bad++; $display("FAIL reload_pre: round=%0d rk=%h expected 5 %h", rk_round, rk, FIPS_RK[5]);
        end
        load(128'h0);
        total++;
        if (rk_round !== 4'd0 || rk !== 128'h0 || rk_valid !== 1'b1) begin
            bad++; $display("FAIL reload_restart: round=%0d rk=%h valid=%b expected 0 0 1",
                            rk_round, rk, rk_valid);
        end
        done_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (done === 1'b1) done_cnt++;
            if (c == 1) begin
                total++;
                if (rk !== ZERO_R1) begin
                    bad++; $display("FAIL reload_r1: got %h expected %h", rk, ZERO_R1);
                end
            end
        end
        total++;
        if (rk !== ZERO_R10 || done !== 1'b1) begin
            bad++; $display("FAIL reload_r10: rk=%h done=%b expected %h 1", rk, done, ZERO_R10);
        end
        tick();
        if (done === 1'b1) done_cnt++;
        total++;
        if (done_cnt != 1) begin
            bad++; $display("FAIL reload_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        for (int i = 0; i < 5; i++) begin
            k = (i == 4) ? FIPS_RK[0] : {4{32'h11111111 * (i + 1)}};
            kld = 1'b1;
            key = k;
            tick();
            total++;
            if (rk_round !== 4'd0 || rk_valid !== 1'b1 || rk !== k || busy !== 1'b1) begin
                bad++; $display("FAIL b2b_load%0d: round=%0d valid=%b busy=%b rk=%h expected 0 1 1 %h",
                                i, rk_round, rk_valid, busy, rk, k);
            end
        end
        kld = 1'b0;
        tick();
        total++;
        if (rk !== FIPS_RK[1] || rk_round !== 4'd1) begin
            bad++; $display("FAIL b2b_r1: rk=%h round=%0d expected %h 1", rk, rk_round, FIPS_RK[1]);
        end
        repeat (9) tick();
        total++;
        if (rk !== FIPS_RK[10] || done !== 1'b1) begin
            bad++; $display("FAIL b2b_r10: rk=%h done=%b expected %h 1", rk, done, FIPS_RK[10]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        load(FIPS_RK[0]);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (rk !== 128'h0 || rd_data !== 128'h0 ||
            {rk_valid, rk_round, done, busy} !== 7'b0) begin
            bad++; $display("FAIL rst_mid_outputs: rk=%h rd_data=%h valid=%b round=%0d done=%b busy=%b expected all 0",
                            rk, rd_data, rk_valid, rk_round, done, busy);
        end
        rd_addr = 4'd3;
        tick();
        total++;
        if (rd_data !== 128'h0) begin
            bad++; $display("FAIL rst_mid_buf3: got %h expected 0", rd_data);
        end
        load(FIPS_RK[0]);
        repeat (10) tick();
        total++;
        if (rk !== FIPS_RK[10] || done !== 1'b1 || rk_round !== 4'd10) begin
            bad++; $display("FAIL rst_mid_reexpand: rk=%h done=%b round=%0d expected %h 1 10",
                            rk, done, rk_round, FIPS_RK[10]);
        end
    endtask

    task automatic test_kld_at_done();
        load(FIPS_RK[0]);
        repeat (10) tick();
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL kdone_pre: done=%b expected 1", done);
        end
        load(128'h0);
        total++;
        if (rk_round !== 4'd0 || rk !== 128'h0 || busy !== 1'b1 ||
            done !== 1'b0 || rk_valid !== 1'b1) begin
            bad++; $display("FAIL kdone_reload: round=%0d rk=%h busy=%b done=%b valid=%b expected 0 0 1 0 1",
                            rk_round, rk, busy, done, rk_valid);
        end
        rd_addr = 4'd12;
        tick();
        total++;
        if (rd_data !== 128'h0) begin
            bad++; $display("FAIL kdone_rd12: got %h expected 0", rd_data);
        end
        total++;
        if (rk !== ZERO_R1) begin
            bad++; $display("FAIL kdone_r1: got %h expected %h", rk, ZERO_R1);
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_readback();
        test_reload_mid();
        test_back_to_back();
        test_reset_mid();
        test_kld_at_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
